// File: rtl/pll_reset_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//  - state_e  : sequencer FSM state encodings (3-bit)
//  - Def*     : default cycle constants for a 25 MHz reference clock
//  - max3     : helper used to size the shared cycle counter
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

  localparam int unsigned DefPllRstCycles = 16;
  localparam int unsigned DefLockTimeout  = 25000;  // 1 ms at 25 MHz
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefMaxRetries   = 3;
  localparam int unsigned DefSyncStages   = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//  clk_i  : destination clock
//  rst_ni : asynchronous active-low reset, all stages clear to 0
//  d_i    : asynchronous input
//  q_o    : synchronised output, STAGES edges behind d_i
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// iCE40 PLL reset sequencer. Holds the PLL in reset, waits for a synchronised lock, qualifies
// it over a stable window and only then releases the system reset. Lock timeouts retry the PLL;
// too many failures latch FAULT until RESET or SW_RESTART.
// Ports:
//  REFERENCECLK : 25 MHz board clock (sole clock)
//  RESET        : asynchronous active-low reset
//  LOCK         : PLL lock, asynchronous
//  SW_RESTART   : 1-cycle pulse, restarts the sequence and clears retries/fault/lock-lost
//  PLL_RESETB   : active-low PLL reset
//  SYS_RESET_N  : active-low system reset, high only in RUN
//  READY        : high in RUN
//  FAULT        : high in FAULT
//  LOCK_LOST    : sticky, lock dropped while in RUN
//  RETRIES      : failed lock attempts so far (saturating)
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned LOCK_TIMEOUT   = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES  = DefStableCycles,
  parameter int unsigned MAX_RETRIES    = DefMaxRetries,
  parameter int unsigned SYNC_STAGES    = DefSyncStages
) (
  input  logic                               REFERENCECLK,
  input  logic                               RESET,
  input  logic                               LOCK,
  input  logic                               SW_RESTART,
  output logic                               PLL_RESETB,
  output logic                               SYS_RESET_N,
  output logic                               READY,
  output logic                               FAULT,
  output logic                               LOCK_LOST,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   RETRIES
);

  localparam int unsigned CntMax = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

  localparam logic [CntW-1:0]   PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRIES);

  logic lk;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (REFERENCECLK),
    .rst_ni (RESET),
    .d_i    (LOCK),
    .q_o    (lk)
  );

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retries_q, retries_d, retries_inc;
  logic              lock_lost_q, lock_lost_d;
  logic              pll_resetb_q, pll_resetb_d;
  logic              sys_reset_n_q, sys_reset_n_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  // Saturating increment so RETRIES never wraps.
  assign retries_inc = (retries_q == RetryMax) ? retries_q : retries_q + RetryW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    lock_lost_d = lock_lost_q;

    unique case (state_q)
      StPllRst: begin
        if (cnt_q == PllRstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lk) begin
          state_d = StStable;
        end else if (cnt_q == TimeoutLast) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RetryMax) ? StFault : StPllRst;
        end
      end
      StStable: begin
        // A lock drop here re-arms the timeout but is not a failed attempt.
        if (!lk) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lk) begin
          lock_lost_d = 1'b1;
          state_d     = StPllRst;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StPllRst;
      end
    endcase

    // Restart overrides any lock or timeout event on the same edge.
    if (SW_RESTART) begin
      state_d     = StPllRst;
      retries_d   = '0;
      lock_lost_d = 1'b0;
    end

    if (state_d == StRun) retries_d = '0;

    // Restart zeroes the counter even if already in PLL_RST.
    if ((state_d != state_q) || SW_RESTART) begin
      cnt_d = '0;
    end else if (state_q inside {StPllRst, StWaitLock, StStable}) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    pll_resetb_d  = state_d inside {StWaitLock, StStable, StRun};
    sys_reset_n_d = (state_d == StRun);
    ready_d       = (state_d == StRun);
    fault_d       = (state_d == StFault);
  end

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= StPllRst;
      cnt_q         <= '0;
      retries_q     <= '0;
      lock_lost_q   <= 1'b0;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retries_q     <= retries_d;
      lock_lost_q   <= lock_lost_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign PLL_RESETB  = pll_resetb_q;
  assign SYS_RESET_N = sys_reset_n_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign LOCK_LOST   = lock_lost_q;
  assign RETRIES     = retries_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed self-checking bench for pll_reset_seq with shortened cycle parameters.
module tb_pll_reset_seq;

  localparam int unsigned PllRstCycles = 4;
  localparam int unsigned LockTimeout  = 20;
  localparam int unsigned StableCycles = 8;
  localparam int unsigned MaxRetries   = 2;
  localparam int unsigned SyncStages   = 2;

  localparam int SelPllResetb = 0;
  localparam int SelSysResetN = 1;
  localparam int SelFault     = 2;
  localparam int SelRetries   = 3;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       sw_restart;
  logic       pll_resetb;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retries;

  int checks = 0;
  int errors = 0;

  pll_reset_seq #(
    .PLL_RST_CYCLES (PllRstCycles),
    .LOCK_TIMEOUT   (LockTimeout),
    .STABLE_CYCLES  (StableCycles),
    .MAX_RETRIES    (MaxRetries),
    .SYNC_STAGES    (SyncStages)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst_n),
    .LOCK         (lock),
    .SW_RESTART   (sw_restart),
    .PLL_RESETB   (pll_resetb),
    .SYS_RESET_N  (sys_reset_n),
    .READY        (ready),
    .FAULT        (fault),
    .LOCK_LOST    (lock_lost),
    .RETRIES      (retries)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int get_sig(input int sel);
    case (sel)
      SelPllResetb: return int'(pll_resetb);
      SelSysResetN: return int'(sys_reset_n);
      SelFault:     return int'(fault);
      default:      return int'(retries);
    endcase
  endfunction

  // Edges until the selected output equals val; -1 if the bound expires.
  task automatic count_until(input int sel, input int val, input int limit, output int n);
    int k;
    k = 0;
    n = -1;
    while (k < limit) begin
      tick();
      k++;
      if (get_sig(sel) == val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    lock       = 1'b0;
    sw_restart = 1'b0;
    ticks(3);

    // Reset state
    check_eq("rst_pll_resetb", pll_resetb, 0);
    check_eq("rst_sys_reset_n", sys_reset_n, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_lock_lost", lock_lost, 0);
    check_eq("rst_retries", retries, 0);

    // 1: basic bring-up
    rst_n = 1'b1;
    count_until(SelPllResetb, 1, 50, n);
    check_eq("t1_pll_rst_len", n, 4);
    ticks(6);
    lock = 1'b1;
    count_until(SelSysResetN, 1, 50, n);
    check_eq("t1_release_latency", n, 11);
    check_eq("t1_ready", ready, 1);
    check_eq("t1_retries", retries, 0);
    check_eq("t1_lock_lost", lock_lost, 0);

    // 3: lock drop in RUN
    lock = 1'b0;
    count_until(SelSysResetN, 0, 20, n);
    check_eq("t3_drop_latency", n, 3);
    check_eq("t3_lock_lost", lock_lost, 1);
    check_eq("t3_pll_resetb_fell", pll_resetb, 0);
    check_eq("t3_ready", ready, 0);
    ticks(2);
    check_eq("t3_pll_resetb_held", pll_resetb, 0);
    lock = 1'b1;
    count_until(SelPllResetb, 1, 20, n);
    check_eq("t3_pll_rst_rest", n, 2);
    count_until(SelSysResetN, 1, 50, n);
    check_eq("t3_rerelease", n, 9);
    check_eq("t3_lock_lost_sticky", lock_lost, 1);

    // 4: lock drop in STABLE at cnt=5; restart also clears LOCK_LOST
    pulse_restart();
    check_eq("t4_restart_lock_lost", lock_lost, 0);
    check_eq("t4_restart_sys", sys_reset_n, 0);
    check_eq("t4_restart_pll", pll_resetb, 0);
    count_until(SelPllResetb, 1, 20, n);
    check_eq("t4_pll_rst_len", n, 4);
    ticks(4);
    lock = 1'b0;
    ticks(3);
    check_eq("t4_no_release", sys_reset_n, 0);
    check_eq("t4_pll_resetb", pll_resetb, 1);
    check_eq("t4_retries", retries, 0);
    lock = 1'b1;
    count_until(SelSysResetN, 1, 50, n);
    check_eq("t4_full_window", n, 11);

    // 2: lock never asserts
    lock = 1'b0;
    pulse_restart();
    count_until(SelRetries, 1, 60, n);
    check_eq("t2_first_timeout", n, 24);
    check_eq("t2_pll_rst_after_to", pll_resetb, 0);
    check_eq("t2_no_fault_yet", fault, 0);
    count_until(SelFault, 1, 60, n);
    check_eq("t2_second_timeout", n, 24);
    check_eq("t2_retries", retries, 2);
    check_eq("t2_pll_resetb", pll_resetb, 0);
    check_eq("t2_sys_reset_n", sys_reset_n, 0);
    ticks(30);
    check_eq("t2_fault_held", fault, 1);
    check_eq("t2_retries_held", retries, 2);
    check_eq("t2_pll_held", pll_resetb, 0);

    // 5: restart from FAULT, then restart coincident with a timeout
    pulse_restart();
    check_eq("t5_fault_cleared", fault, 0);
    check_eq("t5_retries_cleared", retries, 0);
    check_eq("t5_pll_rst", pll_resetb, 0);
    ticks(23);
    check_eq("t5_in_wait_lock", pll_resetb, 1);
    check_eq("t5_pre_retries", retries, 0);
    pulse_restart();
    check_eq("t5_no_increment", retries, 0);
    check_eq("t5_back_to_pll_rst", pll_resetb, 0);
    check_eq("t5_no_fault", fault, 0);
    count_until(SelPllResetb, 1, 20, n);
    check_eq("t5_pll_rst_len", n, 4);

    // 6: asynchronous reset mid-STABLE
    lock = 1'b1;
    ticks(5);
    check_eq("t6_pre_pll_resetb", pll_resetb, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_pll_resetb", pll_resetb, 0);
    check_eq("t6_async_sys", sys_reset_n, 0);
    check_eq("t6_async_retries", retries, 0);
    ticks(3);
    rst_n = 1'b1;
    count_until(SelPllResetb, 1, 20, n);
    check_eq("t6_pll_rst_len", n, 4);
    count_until(SelSysResetN, 1, 50, n);
    check_eq("t6_release", n, 9);
    check_eq("t6_ready", ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
